cosim_commit_queue: RTL and testbench

Buffers and serializes core retirement traffic ahead of the Dromajo co-simulation checker. Each cycle it accepts up to COMMIT_WIDTH retired-instruction records plus an optional trap event from the core's commit stage. It stores them in program order in a circular FIFO and drains one record per cycle on a single-lane interface that drives a width-1 checker port. Traps are ordered strictly after all commits retired in the same or earlier cycles.

---
 rtl/cosim_commit_queue.sv | 163 ++++++++++++++++
 tb/tb_cosim_commit_queue.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cosim_commit_queue.sv
// Commit/trap serializer for the co-simulation checker: packs up to COMMIT_WIDTH
// retirements plus a trap per cycle into a circular FIFO and drains one per cycle.
// Optional feature macro: COSIM_COMMIT_QUEUE_HWM_EN adds the 'hwm' occupancy output.
module cosim_commit_queue #(
    parameter int COMMIT_WIDTH = 2,
    parameter int XLEN         = 64,
    parameter int INST_BITS    = 32,
    parameter int RD           = 5,
    parameter int DEPTH        = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [COMMIT_WIDTH-1:0]      in_valid,
    input  logic [7:0]                   in_hartid,
    input  logic [XLEN*COMMIT_WIDTH-1:0] in_pc,
    input  logic [INST_BITS*COMMIT_WIDTH-1:0] in_inst,
    input  logic [XLEN*COMMIT_WIDTH-1:0] in_wdata,
    input  logic [XLEN*COMMIT_WIDTH-1:0] in_mstatus,
    input  logic [COMMIT_WIDTH-1:0]      in_check,
    input  logic [COMMIT_WIDTH-1:0]      in_wdata_valid,
    input  logic [RD*COMMIT_WIDTH-1:0]   in_wdata_dest,
    input  logic                         in_xcpt,
    input  logic [XLEN-1:0]              in_cause,
    output logic                         in_ready,
    output logic [7:0]                   out_hartid,
    output logic                         out_valid,
    output logic                         out_xcpt,
    output logic [XLEN-1:0]              out_pc,
    output logic [INST_BITS-1:0]         out_inst,
    output logic [XLEN-1:0]              out_wdata,
    output logic [XLEN-1:0]              out_mstatus,
    output logic                         out_check,
    output logic                         out_wdata_valid,
    output logic [RD-1:0]                out_wdata_dest,
    output logic [XLEN-1:0]              out_cause,
    input  logic                         out_ready,
`ifdef COSIM_COMMIT_QUEUE_HWM_EN
    output logic [$clog2(DEPTH):0]       hwm,
`endif
    output logic                         overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Entry storage; not reset, validity is tracked solely by r_count.
    logic                 r_kind    [DEPTH];
    logic [XLEN-1:0]      r_pc      [DEPTH];
    logic [INST_BITS-1:0] r_inst    [DEPTH];
    logic [XLEN-1:0]      r_wdata   [DEPTH];
    logic [XLEN-1:0]      r_mstatus [DEPTH];
    logic                 r_check   [DEPTH];
    logic                 r_wvld    [DEPTH];
    logic [RD-1:0]        r_wdest   [DEPTH];
    logic [XLEN-1:0]      r_cause   [DEPTH];

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic [AW-1:0] w_slot_idx [COMMIT_WIDTH];
    logic [AW-1:0] w_xcpt_idx;
    logic [CW-1:0] w_n_valid;
    logic [CW-1:0] w_n_enq;
    logic [CW-1:0] w_free;
    logic          w_in_ready;
    logic          w_any_in;
    logic          w_enq;
    logic          w_empty;
    logic          w_head_kind;
    logic          w_pop;

    // Compaction: each valid slot lands at wr_ptr + number of valid slots below it.
    always_comb begin
        w_n_valid = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            w_slot_idx[i] = r_wr_ptr + AW'(w_n_valid);
            if (in_valid[i]) begin
                w_n_valid = w_n_valid + CW'(1);
            end
        end
        w_xcpt_idx = r_wr_ptr + AW'(w_n_valid);
    end

    // Admission looks only at the registered count, never at a same-cycle pop.
    assign w_free      = CW'(DEPTH) - r_count;
    assign w_in_ready  = (w_free >= CW'(COMMIT_WIDTH + 1));
    assign w_any_in    = (|in_valid) | in_xcpt;
    assign w_enq       = w_any_in & w_in_ready;
    assign w_n_enq     = w_enq ? (w_n_valid + CW'(in_xcpt)) : '0;

    assign w_empty     = (r_count == '0);
    assign w_head_kind = r_kind[r_rd_ptr];
    assign out_valid   = !w_empty & !w_head_kind;
    assign out_xcpt    = !w_empty &  w_head_kind;
    assign w_pop       = (out_valid | out_xcpt) & out_ready;

    assign in_ready        = w_in_ready;
    assign overflow        = r_overflow;
    assign out_hartid      = in_hartid;
    assign out_pc          = r_pc[r_rd_ptr];
    assign out_inst        = r_inst[r_rd_ptr];
    assign out_wdata       = r_wdata[r_rd_ptr];
    assign out_mstatus     = r_mstatus[r_rd_ptr];
    assign out_check       = r_check[r_rd_ptr];
    assign out_wdata_valid = r_wvld[r_rd_ptr];
    assign out_wdata_dest  = r_wdest[r_rd_ptr];
    assign out_cause       = r_cause[r_rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_n_enq);
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_count  <= r_count + w_n_enq - CW'(w_pop);
            if (w_any_in && !w_in_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Trap entry goes after all commits of the same cycle.
    always_ff @(posedge clock) begin
        if (w_enq) begin
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (in_valid[i]) begin
                    r_kind[w_slot_idx[i]]    <= 1'b0;
                    r_pc[w_slot_idx[i]]      <= in_pc[i*XLEN +: XLEN];
                    r_inst[w_slot_idx[i]]    <= in_inst[i*INST_BITS +: INST_BITS];
                    r_wdata[w_slot_idx[i]]   <= in_wdata[i*XLEN +: XLEN];
                    r_mstatus[w_slot_idx[i]] <= in_mstatus[i*XLEN +: XLEN];
                    r_check[w_slot_idx[i]]   <= in_check[i];
                    r_wvld[w_slot_idx[i]]    <= in_wdata_valid[i];
                    r_wdest[w_slot_idx[i]]   <= in_wdata_dest[i*RD +: RD];
                end
            end
            if (in_xcpt) begin
                r_kind[w_xcpt_idx]  <= 1'b1;
                r_cause[w_xcpt_idx] <= in_cause;
            end
        end
    end

`ifdef COSIM_COMMIT_QUEUE_HWM_EN
    logic [CW-1:0] r_hwm;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_hwm <= '0;
        end else if (r_count > r_hwm) begin
            r_hwm <= r_count;
        end
    end

    assign hwm = r_hwm;
`endif

endmodule

// File: tb/tb_cosim_commit_queue.sv
// Bench for cosim_commit_queue: directed scenarios then random traffic, all
// checked against a queue-based reference model of the commit stream.
module tb_cosim_commit_queue;

    localparam int CWD = 2;
    localparam int DEP = 16;

    logic            clock = 1'b0;
    logic            reset;
    logic [1:0]      in_valid;
    logic [7:0]      in_hartid;
    logic [127:0]    in_pc, in_wdata, in_mstatus;
    logic [63:0]     in_inst;
    logic [1:0]      in_check, in_wdata_valid;
    logic [9:0]      in_wdata_dest;
    logic            in_xcpt;
    logic [63:0]     in_cause;
    logic            in_ready;
    logic [7:0]      out_hartid;
    logic            out_valid, out_xcpt;
    logic [63:0]     out_pc, out_wdata, out_mstatus, out_cause;
    logic [31:0]     out_inst;
    logic            out_check, out_wdata_valid;
    logic [4:0]      out_wdata_dest;
    logic            out_ready;
    logic            overflow;
`ifdef COSIM_COMMIT_QUEUE_HWM_EN
    logic [4:0]      hwm;
`endif

    cosim_commit_queue #(.COMMIT_WIDTH(CWD), .XLEN(64), .INST_BITS(32), .RD(5), .DEPTH(DEP)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_hartid(in_hartid),
        .in_pc(in_pc), .in_inst(in_inst), .in_wdata(in_wdata), .in_mstatus(in_mstatus),
        .in_check(in_check), .in_wdata_valid(in_wdata_valid), .in_wdata_dest(in_wdata_dest),
        .in_xcpt(in_xcpt), .in_cause(in_cause), .in_ready(in_ready), .out_hartid(out_hartid),
        .out_valid(out_valid), .out_xcpt(out_xcpt), .out_pc(out_pc), .out_inst(out_inst),
        .out_wdata(out_wdata), .out_mstatus(out_mstatus), .out_check(out_check),
        .out_wdata_valid(out_wdata_valid), .out_wdata_dest(out_wdata_dest),
        .out_cause(out_cause), .out_ready(out_ready),
`ifdef COSIM_COMMIT_QUEUE_HWM_EN
        .hwm(hwm),
`endif
        .overflow(overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          kind;
        logic [63:0] pc;
        logic [31:0] inst;
        logic [63:0] wdata;
        logic [63:0] mstatus;
        logic        check;
        logic        wvld;
        logic [4:0]  wdest;
        logic [63:0] cause;
    } ent_t;

    ent_t q[$];
    bit   m_ovf;
    int   m_hwm;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit nonempty;
        nonempty = (q.size() > 0);
        chk("in_ready", in_ready, ((DEP - q.size()) >= CWD + 1));
        chk("out_valid", out_valid, nonempty && !q[0].kind);
        chk("out_xcpt", out_xcpt, nonempty && q[0].kind);
        chk("excl", out_valid & out_xcpt, 0);
        chk("overflow", overflow, m_ovf);
        chk("hartid", out_hartid, in_hartid);
`ifdef COSIM_COMMIT_QUEUE_HWM_EN
        chk("hwm", hwm, m_hwm);
`endif
        if (nonempty) begin
            if (!q[0].kind) begin
                chk("pc", out_pc, q[0].pc);
                chk("inst", out_inst, q[0].inst);
                chk("wdata", out_wdata, q[0].wdata);
                chk("mstatus", out_mstatus, q[0].mstatus);
                chk("check", out_check, q[0].check);
                chk("wvld", out_wdata_valid, q[0].wvld);
                chk("wdest", out_wdata_dest, q[0].wdest);
            end else begin
                chk("cause", out_cause, q[0].cause);
            end
        end
    endtask

    // Reference behaviour of one clock edge given the currently driven inputs.
    task automatic model_edge();
        int   sz;
        bit   rdy, any;
        ent_t e;
        sz  = q.size();
        rdy = (DEP - sz) >= CWD + 1;
        any = (in_valid != 0) || in_xcpt;
        if (sz > m_hwm) m_hwm = sz;
        if (sz > 0 && out_ready) void'(q.pop_front());
        if (any && rdy) begin
            for (int i = 0; i < CWD; i++) begin
                if (in_valid[i]) begin
                    e.kind = 0; e.pc = in_pc[i*64 +: 64]; e.inst = in_inst[i*32 +: 32];
                    e.wdata = in_wdata[i*64 +: 64]; e.mstatus = in_mstatus[i*64 +: 64];
                    e.check = in_check[i]; e.wvld = in_wdata_valid[i];
                    e.wdest = in_wdata_dest[i*5 +: 5]; e.cause = '0;
                    q.push_back(e);
                end
            end
            if (in_xcpt) begin
                e = '{default: '0};
                e.kind = 1; e.cause = in_cause;
                q.push_back(e);
            end
        end else if (any) begin
            m_ovf = 1;
        end
    endtask

    task automatic step();
        @(negedge clock);
        check_outputs();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic rand_fields();
        in_hartid      = 8'($urandom);
        in_pc          = {$urandom, $urandom, $urandom, $urandom};
        in_inst        = {$urandom, $urandom};
        in_wdata       = {$urandom, $urandom, $urandom, $urandom};
        in_mstatus     = {$urandom, $urandom, $urandom, $urandom};
        in_check       = 2'($urandom);
        in_wdata_valid = 2'($urandom);
        in_wdata_dest  = 10'($urandom);
        in_cause       = {$urandom, $urandom};
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            rand_fields();
            in_valid = '0;
            in_xcpt  = 0;
            step();
        end
    endtask

    task automatic enq(input logic [1:0] v, input logic x, input logic [63:0] pc0, input logic [63:0] pc1);
        rand_fields();
        in_valid = v;
        in_xcpt  = x;
        in_pc    = {pc1, pc0};
        step();
    endtask

    task automatic do_reset();
        #3;
        reset = 0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_xcpt", out_xcpt, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_overflow", overflow, 0);
`ifdef COSIM_COMMIT_QUEUE_HWM_EN
        chk("rst_hwm", hwm, 0);
`endif
        q.delete();
        m_ovf = 0;
        m_hwm = 0;
        @(negedge clock);
        reset = 1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1;
        out_ready = 1;
        in_valid = '0;
        in_xcpt = 0;
        rand_fields();
        m_ovf = 0;
        m_hwm = 0;
        #2;
        do_reset();

        // Two-slot retire drains in order.
        out_ready = 1;
        enq(2'b11, 0, 64'h1000, 64'h1004);
        idle(3);

        // Slot 1 commit followed by same-cycle trap.
        in_cause = 64'h8000000000000007;
        rand_fields();
        in_valid = 2'b10;
        in_xcpt  = 1;
        in_pc    = {64'h2004, 64'h0};
        in_cause = 64'h8000000000000007;
        step();
        idle(3);

        // Fill to 14 with out_ready low, then overflow.
        out_ready = 0;
        enq(2'b11, 0, 64'h10, 64'h14);
        for (int k = 0; k < 5; k++) enq(2'b11, 1, 64'h100 + 64'(k*8), 64'h104 + 64'(k*8));
        chk("ovf_set", overflow, 1);
        chk("full_in_ready", in_ready, 0);
        enq(2'b01, 0, 64'h900, 64'h0);
        out_ready = 1;
        idle(17);

        // Sustained 2-in / 1-out with pointer wrap until stall.
        for (int k = 0; k < 40; k++) enq(2'b11, 0, 64'h4000 + 64'(k*8), 64'h4004 + 64'(k*8));
        idle(18);

        // Reset with five queued entries discards them.
        out_ready = 0;
        enq(2'b11, 0, 64'h50, 64'h54);
        enq(2'b11, 0, 64'h58, 64'h5c);
        enq(2'b01, 0, 64'h60, 64'h0);
        in_valid = '0;
        in_xcpt = 0;
        do_reset();
        out_ready = 1;
        enq(2'b01, 0, 64'h3000, 64'h0);
        idle(3);

        // Six entries in, none out, then drain.
        do_reset();
        out_ready = 0;
        for (int k = 0; k < 3; k++) enq(2'b11, 0, 64'h6000 + 64'(k*8), 64'h6004 + 64'(k*8));
        idle(2);
        out_ready = 1;
        idle(8);
`ifdef COSIM_COMMIT_QUEUE_HWM_EN
        chk("hwm_hold", hwm, 6);
`endif

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            rand_fields();
            in_valid  = 2'($urandom);
            in_xcpt   = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        out_ready = 1;
        idle(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
